// File: rtl/wdt_pkg.sv
// -----------------------------------------------------------------------------
// wdt_pkg
// Shared types and default constants for the watchdog timer.
//   wdt_state_t     : FSM state encoding (IDLE, RUN, BITE)
//   *_DEF_C         : default parameter values used by watch_dog_timer
//   PULSE_CNT_W     : width of the reset-pulse length counter (PULSE_W <= 255)
// -----------------------------------------------------------------------------
package wdt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        BITE = 2'd2
    } wdt_state_t;

    localparam int          CNT_W_DEF_C      = 24;
    localparam logic [23:0] TIMEOUT_DEF_C    = 24'd5_000_000;
    localparam logic [23:0] WIN_DEF_C        = 24'd0;
    localparam int          PULSE_W_DEF_C    = 16;
    localparam int          BITE_CNT_W_DEF_C = 8;
    localparam int          PULSE_CNT_W      = 8;

endpackage : wdt_pkg

// File: rtl/wdt_pulse_gen.sv
// -----------------------------------------------------------------------------
// wdt_pulse_gen
// Turns a one-cycle load strobe into an output held high for exactly PULSE_W
// clock cycles, starting the cycle after the load edge. A synchronous reset
// aborts a pulse in progress.
//   clk     in   system clock
//   rest    in   synchronous active-low reset
//   i_load  in   start a new pulse (ignored while one is running)
//   o_pulse out  registered pulse output
//   o_done  out  high during the last cycle of the pulse
// -----------------------------------------------------------------------------
module wdt_pulse_gen
    import wdt_pkg::*;
#(
    parameter int PULSE_W = PULSE_W_DEF_C
) (
    input  logic clk,
    input  logic rest,
    input  logic i_load,
    output logic o_pulse,
    output logic o_done
);

    logic                   r_pulse;
    logic [PULSE_CNT_W-1:0] r_cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rest) begin
            r_pulse <= 1'b0;
            r_cnt   <= '0;
        end else if (r_pulse) begin
            // r_cnt counts the remaining high cycles after the current one.
            if (r_cnt == '0) begin
                r_pulse <= 1'b0;
            end else begin
                r_cnt <= r_cnt - PULSE_CNT_W'(1);
            end
        end else if (i_load) begin
            r_pulse <= 1'b1;
            r_cnt   <= PULSE_CNT_W'(PULSE_W - 1);
        end
    end

    assign o_pulse = r_pulse;
    assign o_done  = r_pulse && (r_cnt == '0);

endmodule : wdt_pulse_gen

// File: rtl/watch_dog_timer.sv
// -----------------------------------------------------------------------------
// watch_dog_timer
// Free-running down-counter the CPU must kick before it expires. On expiry, or
// on a kick arriving before the window opens, it issues a PULSE_W-cycle reset
// pulse to the CPU core and records the event.
//   clk          in   system clock
//   rest         in   synchronous active-low reset
//   en           in   watchdog enable (level)
//   kick         in   one-cycle kick strobe
//   cfg_we       in   latch cfg_timeout / cfg_win
//   cfg_timeout  in   new reload value (0 is treated as 1)
//   cfg_win      in   new window-open threshold (0 disables the window)
//   rst          out  active-high reset pulse to the CPU core
//   bite         out  one-cycle strobe on entry to BITE
//   early_err    out  last bite was caused by an early kick
//   bite_cnt     out  saturating bite counter
//   count        out  live counter value
// -----------------------------------------------------------------------------
module watch_dog_timer
    import wdt_pkg::*;
#(
    parameter int               CNT_W       = CNT_W_DEF_C,
    parameter logic [CNT_W-1:0] TIMEOUT_DEF = CNT_W'(TIMEOUT_DEF_C),
    parameter logic [CNT_W-1:0] WIN_DEF     = CNT_W'(WIN_DEF_C),
    parameter int               PULSE_W     = PULSE_W_DEF_C,
    parameter int               BITE_CNT_W  = BITE_CNT_W_DEF_C
) (
    input  logic                  clk,
    input  logic                  rest,
    input  logic                  en,
    input  logic                  kick,
    input  logic                  cfg_we,
    input  logic [CNT_W-1:0]      cfg_timeout,
    input  logic [CNT_W-1:0]      cfg_win,
    output logic                  rst,
    output logic                  bite,
    output logic                  early_err,
    output logic [BITE_CNT_W-1:0] bite_cnt,
    output logic [CNT_W-1:0]      count
);

    wdt_state_t            r_state;
    logic [CNT_W-1:0]      r_count;
    logic [CNT_W-1:0]      r_timeout;
    logic [CNT_W-1:0]      r_win;
    logic                  r_bite;
    logic                  r_early_err;
    logic [BITE_CNT_W-1:0] r_bite_cnt;

    logic w_early_kick;
    logic w_expire;
    logic w_bite_entry;
    logic w_pulse;
    logic w_pulse_done;

    // A kick is early only while the window is enabled and not yet open.
    assign w_early_kick = kick && (r_win != '0) && (r_count > r_win);
    // A valid kick on the zero cycle still reloads, so expiry needs no kick.
    assign w_expire     = !kick && (r_count == '0);
    assign w_bite_entry = (r_state == RUN) && en && (w_early_kick || w_expire);

    wdt_pulse_gen #(
        .PULSE_W (PULSE_W)
    ) u_pulse_gen (
        .clk     (clk),
        .rest    (rest),
        .i_load  (w_bite_entry),
        .o_pulse (w_pulse),
        .o_done  (w_pulse_done)
    );

    always_ff @(posedge clk) begin
        if (!rest) begin
            r_state     <= IDLE;
            r_count     <= TIMEOUT_DEF;
            r_timeout   <= TIMEOUT_DEF;
            r_win       <= WIN_DEF;
            r_bite      <= 1'b0;
            r_early_err <= 1'b0;
            r_bite_cnt  <= '0;
        end else begin
            r_bite <= 1'b0;

            // Config only lands in the reload registers; count picks it up at
            // the next reload.
            if (cfg_we) begin
                r_timeout <= (cfg_timeout == '0) ? CNT_W'(1) : cfg_timeout;
                r_win     <= cfg_win;
            end

            case (r_state)
                IDLE: begin
                    r_count <= r_timeout;
                    if (en) begin
                        r_state <= RUN;
                    end
                end

                RUN: begin
                    if (!en) begin
                        r_state <= IDLE;
                        r_count <= r_timeout;
                    end else if (w_bite_entry) begin
                        r_state     <= BITE;
                        r_bite      <= 1'b1;
                        r_early_err <= w_early_kick;
                        if (r_bite_cnt != '1) begin
                            r_bite_cnt <= r_bite_cnt + BITE_CNT_W'(1);
                        end
                    end else if (kick) begin
                        r_count <= r_timeout;
                    end else begin
                        r_count <= r_count - CNT_W'(1);
                    end
                end

                BITE: begin
                    // en and kick are ignored until the pulse has run out.
                    if (w_pulse_done) begin
                        r_state <= en ? RUN : IDLE;
                        r_count <= r_timeout;
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_count <= r_timeout;
                end
            endcase
        end
    end

    assign rst       = w_pulse;
    assign bite      = r_bite;
    assign early_err = r_early_err;
    assign bite_cnt  = r_bite_cnt;
    assign count     = r_count;

endmodule : watch_dog_timer

// File: doc/watch_dog_timer.md
Name: watch_dog_timer

Overview:
- Parametrised successor to the single-channel CPU watchdog: free-running down-counter that the CPU must "kick" before it expires.
- On expiry, or on an illegal early kick in window mode, it drives a fixed-width reset pulse `rst` to the CPU core and records the event.
- Sits beside the CPU/bus top level; `kick` and config are driven from a bus-mapped register; `rst` is ORed into the core reset tree.

Parameters:
- CNT_W, 24, width of the timeout counter and of cfg_timeout.
- TIMEOUT_DEF, 24'd5_000_000, timeout reload value after reset.
- WIN_DEF, 24'd0, window-open threshold after reset; 0 means the window is disabled.
- PULSE_W, 16, width in clk cycles of the rst pulse (range 1..255).
- BITE_CNT_W, 8, width of the saturating bite counter.

Ports:
- clk  input  1  system clock
- rest  input  1  reset; synchronous, active-low
- en  input  1  watchdog enable; level-sensitive
- kick  input  1  one-cycle kick strobe from the bus register
- cfg_we  input  1  write strobe for cfg_timeout/cfg_win
- cfg_timeout  input  CNT_W  new timeout reload value
- cfg_win  input  CNT_W  new window-open threshold
- rst  output  1  active-high reset pulse to the CPU core
- bite  output  1  one-cycle strobe on entry to BITE
- early_err  output  1  sticky: last bite was caused by an early kick
- bite_cnt  output  BITE_CNT_W  number of bites, saturating
- count  output  CNT_W  live counter value, for readback

Behaviour:
- Reset is synchronous and active-low (`rest`=0 at a clk edge):
  - state=IDLE, count=TIMEOUT_DEF, timeout_r=TIMEOUT_DEF, win_r=WIN_DEF, pulse counter=0.
  - rst=0, bite=0, early_err=0, bite_cnt=0.
- `rest` asserted mid-pulse aborts the pulse: rst=0 on the next cycle.
- Config:
  - cfg_we=1 latches cfg_timeout into timeout_r and cfg_win into win_r, in any state.
  - The new values take effect at the next reload; count is never modified directly.
  - cfg_timeout=0 is clamped to 1 at latch time.
- Valid kick: kick=1 while (win_r==0 or count<=win_r). Early kick: kick=1 while win_r!=0 and count>win_r.
- FSM states are IDLE, RUN and BITE. One priority rule applies per cycle in RUN.
- IDLE:
  - count held at timeout_r, rst=0.
  - en=1 -> RUN, with count<=timeout_r.
- RUN (priority order):
  1. en=0 -> IDLE, count<=timeout_r.
  2. Early kick -> BITE, early_err<=1.
  3. Valid kick -> count<=timeout_r.
  4. count==0 -> BITE, early_err<=0.
  5. Otherwise count<=count-1.
- Kick timing consequences:
  - A valid kick on the cycle count==0 still wins; no bite occurs.
  - With no kicks, BITE is entered exactly timeout_r+1 cycles after the reload edge.
- Entry to BITE (registered):
  - bite=1 for exactly one cycle.
  - bite_cnt increments, saturating at all-ones.
  - rst=1 starting the same cycle as bite.
- BITE:
  - rst is held high for exactly PULSE_W cycles; en and kick are ignored.
  - After the pulse, rst=0 and the state is entered with count<=timeout_r:
    - en=1 -> RUN
    - en=0 -> IDLE
- early_err updates only on BITE entry; it is otherwise held.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- The count output equals the internal counter.

Decomposition:
- Package `wdt_pkg`: state enum (IDLE=2'd0, RUN=2'd1, BITE=2'd2) and the default-constant localparams.
- One sub-module: `wdt_pulse_gen` (load strobe -> PULSE_W-cycle high output, with abort on reset).
- The counter and FSM stay in the top module.

Test Plan:
1. Expiry: TIMEOUT_DEF=10, PULSE_W=4, en=1, no kicks -> bite strobe at cycle 11 after RUN entry; rst high for 4 cycles; bite_cnt=1; early_err=0; counter then restarts at 10.
2. Periodic kicks: valid kick every 8 cycles with timeout 10 -> rst never asserts over 200 cycles; count never drops below 2.
3. Kick at zero: kick exactly on the cycle count==0 -> no bite; count=10 the next cycle.
4. Window mode: cfg_we with cfg_timeout=20, cfg_win=5, then en=1:
   - kick at count=12 -> bite next cycle, early_err=1;
   - kick at count=3 -> reload to 20, no bite.
5. Disable and reset: en=0 mid-RUN at count=4 -> IDLE, count=10, no bite; `rest`=0 during BITE pulse cycle 2 -> rst=0 and bite_cnt=0 the next cycle.
6. Saturation: BITE_CNT_W=2, force 5 expiries -> bite_cnt sticks at 3; a config write during RUN leaves count unchanged until the next reload.
